// File: rtl/mdll_dcdl_coarse_if.sv
// Control/status bundle between the MDLL fine loop and the DCDL coarse controller.
interface mdll_dcdl_coarse_if #(
    parameter int unsigned N_STG = 16
);
    localparam int unsigned W = $clog2(N_STG);

    logic             mode;
    logic [W-1:0]     code_tgt;
    logic             load;
    logic             inc;
    logic             dec;
    logic [N_STG-1:0] en_ff;
    logic [W-1:0]     code_cur;
    logic             busy;
    logic             sat_hi;
    logic             sat_lo;

    modport master (
        output mode, code_tgt, load, inc, dec,
        input  en_ff, code_cur, busy, sat_hi, sat_lo
    );

    modport slave (
        input  mode, code_tgt, load, inc, dec,
        output en_ff, code_cur, busy, sat_hi, sat_lo
    );
endinterface

// File: rtl/mdll_dcdl_coarse_ctrl.sv
// Coarse-code controller for the MDLL delay line: walks code_cur one stage at a
// time toward a latched target and drives a thermometer of feed-forward enables.
module mdll_dcdl_coarse_ctrl #(
    parameter int unsigned N_STG     = 16,
    parameter int unsigned STEP_WAIT = 4,
    parameter int unsigned RST_CODE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    mdll_dcdl_coarse_if.slave  bus
);
    localparam int unsigned W  = $clog2(N_STG);
    localparam int unsigned CW = (STEP_WAIT > 1) ? $clog2(STEP_WAIT) : 1;

    localparam logic [W-1:0]  CODE_MAX = W'(N_STG - 1);
    localparam logic [W-1:0]  CODE_RST = W'(RST_CODE);
    localparam logic [CW-1:0] CNT_LAST = CW'((STEP_WAIT == 0) ? 0 : (STEP_WAIT - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [W-1:0]     code_q, code_nx;
    logic [W-1:0]     tgt_q, tgt_nx;
    logic [CW-1:0]    cnt_q, cnt_nx;
    logic [N_STG-1:0] en_q;
    logic             busy_q, sat_hi_q, sat_lo_q;
    logic             sat_hi_nx, sat_lo_nx;
    logic             load_acc_c, clamp_c, trk_req_c;

    // Thermometer: stages below the code feed forward; the top stage never does.
    function automatic logic [N_STG-1:0] therm(input logic [W-1:0] c);
        logic [N_STG-1:0] t;
        t = '0;
        for (int i = 0; i < N_STG - 1; i++) begin
            t[i] = (W'(i) < c);
        end
        t[N_STG-1] = 1'b0;
        return t;
    endfunction

    assign load_acc_c = !bus.mode && bus.load;
    assign clamp_c    = (32'(bus.code_tgt) > (N_STG - 1));
    assign trk_req_c  = bus.mode && (bus.inc ^ bus.dec) && (state == S_IDLE);

    // Next-state, target latch and step decision.
    always_comb begin
        state_nx  = state;
        code_nx   = code_q;
        tgt_nx    = tgt_q;
        cnt_nx    = cnt_q;
        sat_hi_nx = 1'b0;
        sat_lo_nx = 1'b0;

        // A direct load retargets in any state; stepping continues from code_q.
        if (load_acc_c) begin
            tgt_nx    = clamp_c ? CODE_MAX : bus.code_tgt;
            sat_hi_nx = clamp_c;
        end

        case (state)
            S_IDLE: begin
                if (load_acc_c) begin
                    if (tgt_nx != code_q) begin
                        state_nx = S_STEP;
                    end
                end else if (trk_req_c) begin
                    if (bus.inc) begin
                        if (code_q == CODE_MAX) begin
                            sat_hi_nx = 1'b1;
                        end else begin
                            tgt_nx   = code_q + W'(1);
                            state_nx = S_STEP;
                        end
                    end else begin
                        if (code_q == '0) begin
                            sat_lo_nx = 1'b1;
                        end else begin
                            tgt_nx   = code_q - W'(1);
                            state_nx = S_STEP;
                        end
                    end
                end
            end

            S_STEP: begin
                if (code_q < tgt_nx) begin
                    code_nx = code_q + W'(1);
                end else if (code_q > tgt_nx) begin
                    code_nx = code_q - W'(1);
                end
                cnt_nx = '0;
                if (STEP_WAIT == 0) begin
                    state_nx = (code_nx == tgt_nx) ? S_IDLE : S_STEP;
                end else begin
                    state_nx = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = (code_q == tgt_nx) ? S_IDLE : S_STEP;
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; en_ff tracks code_cur on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            code_q   <= CODE_RST;
            tgt_q    <= CODE_RST;
            cnt_q    <= '0;
            en_q     <= therm(CODE_RST);
            busy_q   <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            state    <= state_nx;
            code_q   <= code_nx;
            tgt_q    <= tgt_nx;
            cnt_q    <= cnt_nx;
            en_q     <= therm(code_nx);
            busy_q   <= (state_nx != S_IDLE);
            sat_hi_q <= sat_hi_nx;
            sat_lo_q <= sat_lo_nx;
        end
    end

    assign bus.en_ff    = en_q;
    assign bus.code_cur = code_q;
    assign bus.busy     = busy_q;
    assign bus.sat_hi   = sat_hi_q;
    assign bus.sat_lo   = sat_lo_q;
endmodule

// File: tb/tb_mdll_dcdl_coarse_ctrl.sv
// Self-checking bench for mdll_dcdl_coarse_ctrl: three parameterisations checked
// every cycle against a step-schedule model, plus hand-computed edge checks.
module tb_mdll_dcdl_coarse_ctrl;
    logic       clk;
    logic [2:0] rst_v;
    int         nchk;
    int         nerr;
    bit         cmp_en;

    typedef struct packed {
        int code;
        int tgt;
        int tn;
        bit busy;
        bit shi;
        bit slo;
        bit rs;
    } mst_t;

    mst_t        m0, m1, m2;
    logic [63:0] prev_en [3];

    mdll_dcdl_coarse_if #(.N_STG(16)) b0 ();
    mdll_dcdl_coarse_if #(.N_STG(16)) b1 ();
    mdll_dcdl_coarse_if #(.N_STG(12)) b2 ();

    mdll_dcdl_coarse_ctrl #(.N_STG(16), .STEP_WAIT(4), .RST_CODE(0)) u0 (
        .clk(clk), .rst(rst_v[0]), .bus(b0));
    mdll_dcdl_coarse_ctrl #(.N_STG(16), .STEP_WAIT(4), .RST_CODE(3)) u1 (
        .clk(clk), .rst(rst_v[1]), .bus(b1));
    mdll_dcdl_coarse_ctrl #(.N_STG(12), .STEP_WAIT(0), .RST_CODE(0)) u2 (
        .clk(clk), .rst(rst_v[2]), .bus(b2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Step-schedule model: a request schedules a step one edge later, then one
    // step every sw+1 edges; the block goes idle once the code reaches target
    // at the edge that precedes the next scheduled step.
    function automatic mst_t mstep(input mst_t s, input bit r_in, input bit md, input int ct,
                                   input bit ld, input bit ic, input bit dc,
                                   input int n, input int sw, input int rc);
        mst_t r;
        bit   wb;
        r     = s;
        r.shi = 1'b0;
        r.slo = 1'b0;
        r.rs  = 1'b0;
        if (r_in) begin
            r.code = rc; r.tgt = rc; r.busy = 1'b0; r.tn = 0; r.rs = 1'b1;
            return r;
        end
        wb = s.busy;
        if (!md && ld) begin
            r.shi = (ct > n - 1);
            r.tgt = r.shi ? n - 1 : ct;
            if (!wb && r.tgt != s.code) begin r.busy = 1'b1; r.tn = 1; end
        end else if (md && !wb && (ic != dc)) begin
            if (ic && s.code == n - 1)  r.shi = 1'b1;
            else if (dc && s.code == 0) r.slo = 1'b1;
            else begin
                r.tgt  = ic ? s.code + 1 : s.code - 1;
                r.busy = 1'b1;
                r.tn   = 1;
            end
        end
        if (wb) begin
            r.tn = r.tn - 1;
            if (r.tn == 0) begin
                if (r.code < r.tgt)      r.code = r.code + 1;
                else if (r.code > r.tgt) r.code = r.code - 1;
                r.tn = sw + 1;
            end
            if (r.tn == 1 && r.code == r.tgt) r.busy = 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m0 <= mstep(m0, rst_v[0], b0.mode, int'(b0.code_tgt), b0.load, b0.inc, b0.dec, 16, 4, 0);
        m1 <= mstep(m1, rst_v[1], b1.mode, int'(b1.code_tgt), b1.load, b1.inc, b1.dec, 16, 4, 3);
        m2 <= mstep(m2, rst_v[2], b2.mode, int'(b2.code_tgt), b2.load, b2.inc, b2.dec, 12, 0, 0);
    end

    task automatic cmp_one(input int idx, input string nm, input int code, input logic [63:0] en,
                           input bit busy, input bit shi, input bit slo, input mst_t m);
        logic [63:0] exp_en;
        exp_en = (64'(1) << m.code) - 64'(1);
        chk({nm, ".code_cur"}, 64'(code), 64'(m.code));
        chk({nm, ".en_ff"}, en, exp_en);
        chk({nm, ".busy"}, 64'(busy), 64'(m.busy));
        chk({nm, ".sat_hi"}, 64'(shi), 64'(m.shi));
        chk({nm, ".sat_lo"}, 64'(slo), 64'(m.slo));
        if (!m.rs) chk({nm, ".one_bit_toggle"}, 64'($countones(en ^ prev_en[idx]) <= 1), 64'(1));
        prev_en[idx] = en;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_one(0, "u0", int'(b0.code_cur), 64'(b0.en_ff), b0.busy, b0.sat_hi, b0.sat_lo, m0);
            cmp_one(1, "u1", int'(b1.code_cur), 64'(b1.en_ff), b1.busy, b1.sat_hi, b1.sat_lo, m1);
            cmp_one(2, "u2", int'(b2.code_cur), 64'(b2.en_ff), b2.busy, b2.sat_hi, b2.sat_lo, m2);
        end
    end

    task automatic drv(input int inst, input bit md, input int tg, input bit ld,
                       input bit ic, input bit dc);
        case (inst)
            0: begin b0.mode = md; b0.code_tgt = 4'(tg); b0.load = ld; b0.inc = ic; b0.dec = dc; end
            1: begin b1.mode = md; b1.code_tgt = 4'(tg); b1.load = ld; b1.inc = ic; b1.dec = dc; end
            default: begin b2.mode = md; b2.code_tgt = 4'(tg); b2.load = ld; b2.inc = ic; b2.dec = dc; end
        endcase
    endtask

    // Present a request for one edge; returns at the negedge after that edge.
    task automatic pulse(input int inst, input bit md, input int tg, input bit ld,
                         input bit ic, input bit dc);
        drv(inst, md, tg, ld, ic, dc);
        @(negedge clk);
        drv(inst, md, tg, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit busy_of(input int inst);
        case (inst)
            0:       return b0.busy;
            1:       return b1.busy;
            default: return b2.busy;
        endcase
    endfunction

    task automatic wait_idle(input int inst, input int budget);
        int k;
        k = 0;
        while (busy_of(inst) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle_budget", 64'(busy_of(inst)), 64'(0));
    endtask

    task automatic wait_code0(input int val, input int budget);
        int k;
        k = 0;
        while (int'(b0.code_cur) != val && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_code_budget", 64'(b0.code_cur), 64'(val));
    endtask

    initial begin
        nchk   = 0;
        nerr   = 0;
        cmp_en = 1'b0;
        rst_v  = 3'b111;
        for (int i = 0; i < 3; i++) begin
            drv(i, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            prev_en[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst_v  = 3'b000;
        cmp_en = 1'b1;

        // Reset state
        chk("rst.u0.code", 64'(b0.code_cur), 64'd0);
        chk("rst.u0.en", 64'(b0.en_ff), 64'h0);
        chk("rst.u0.busy", 64'(b0.busy), 64'd0);
        chk("rst.u1.code", 64'(b1.code_cur), 64'd3);
        chk("rst.u1.en", 64'(b1.en_ff), 64'h7);

        // Direct ramp 0 -> 5, load sampled at edge 0
        pulse(0, 1'b0, 5, 1'b1, 1'b0, 1'b0);
        chk("ramp.e0.busy", 64'(b0.busy), 64'd1);
        chk("ramp.e0.code", 64'(b0.code_cur), 64'd0);
        @(negedge clk);
        chk("ramp.e1.code", 64'(b0.code_cur), 64'd1);
        chk("ramp.e1.en", 64'(b0.en_ff), 64'h1);
        repeat (5) @(negedge clk);
        chk("ramp.e6.code", 64'(b0.code_cur), 64'd2);
        repeat (15) @(negedge clk);
        chk("ramp.e21.code", 64'(b0.code_cur), 64'd5);
        repeat (3) @(negedge clk);
        chk("ramp.e24.busy", 64'(b0.busy), 64'd1);
        @(negedge clk);
        chk("ramp.e25.busy", 64'(b0.busy), 64'd0);
        chk("ramp.e25.en", 64'(b0.en_ff), 64'h001F);

        // Load equal to current code: no busy pulse
        pulse(0, 1'b0, 5, 1'b1, 1'b0, 1'b0);
        chk("same.busy", 64'(b0.busy), 64'd0);

        // Top of range 14 -> 15
        pulse(0, 1'b0, 14, 1'b1, 1'b0, 1'b0);
        wait_idle(0, 200);
        pulse(0, 1'b0, 15, 1'b1, 1'b0, 1'b0);
        chk("top.sat_hi", 64'(b0.sat_hi), 64'd0);
        wait_idle(0, 50);
        chk("top.code", 64'(b0.code_cur), 64'd15);
        chk("top.en", 64'(b0.en_ff), 64'h7FFF);
        chk("top.en15", 64'(b0.en_ff[15]), 64'd0);

        // Track mode saturation high, then a dec with an inc dropped while busy
        pulse(0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        chk("trk.sathi", 64'(b0.sat_hi), 64'd1);
        chk("trk.sathi.code", 64'(b0.code_cur), 64'd15);
        @(negedge clk);
        chk("trk.sathi.pulse", 64'(b0.sat_hi), 64'd0);
        pulse(0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        chk("trk.dec.busy", 64'(b0.busy), 64'd1);
        pulse(0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        wait_idle(0, 50);
        chk("trk.drop.code", 64'(b0.code_cur), 64'd14);
        pulse(0, 1'b1, 0, 1'b0, 1'b1, 1'b1);
        chk("trk.both.busy", 64'(b0.busy), 64'd0);
        pulse(0, 1'b1, 7, 1'b1, 1'b0, 1'b0);
        chk("trk.load_ign", 64'(b0.busy), 64'd0);
        pulse(0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("dir.inc_ign", 64'(b0.busy), 64'd0);
        chk("dir.inc_ign.code", 64'(b0.code_cur), 64'd14);

        // Back to 0, then saturation low
        pulse(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        wait_idle(0, 200);
        chk("down.code", 64'(b0.code_cur), 64'd0);
        pulse(0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        chk("trk.satlo", 64'(b0.sat_lo), 64'd1);
        @(negedge clk);
        chk("trk.satlo.pulse", 64'(b0.sat_lo), 64'd0);

        // Mode flips back to direct while an inc is in flight
        pulse(0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        drv(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        wait_idle(0, 50);
        chk("modechg.code", 64'(b0.code_cur), 64'd1);
        pulse(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        wait_idle(0, 50);

        // Retarget 8 -> 2 while code_cur is 4
        pulse(0, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        wait_code0(4, 100);
        pulse(0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        chk("retgt.code4", 64'(b0.code_cur), 64'd4);
        wait_idle(0, 100);
        chk("retgt.code", 64'(b0.code_cur), 64'd2);
        chk("retgt.en", 64'(b0.en_ff), 64'h3);

        // Reset mid-ramp on the RST_CODE=3 instance, with a load during reset
        pulse(1, 1'b0, 10, 1'b1, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        chk("rmid.code_before", 64'(b1.code_cur), 64'd5);
        rst_v[1] = 1'b1;
        drv(1, 1'b0, 12, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_v[1] = 1'b0;
        drv(1, 1'b0, 12, 1'b0, 1'b0, 1'b0);
        chk("rmid.code", 64'(b1.code_cur), 64'd3);
        chk("rmid.en", 64'(b1.en_ff), 64'h0007);
        chk("rmid.busy", 64'(b1.busy), 64'd0);
        @(negedge clk);
        chk("rmid.after.busy", 64'(b1.busy), 64'd0);
        chk("rmid.after.code", 64'(b1.code_cur), 64'd3);

        // STEP_WAIT=0: one step per edge, 0 -> 4
        pulse(2, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        chk("sw0.e0.code", 64'(b2.code_cur), 64'd0);
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            chk("sw0.code", 64'(b2.code_cur), 64'(e));
            chk("sw0.busy", 64'(b2.busy), 64'(e < 4));
        end

        // N_STG=12: out-of-range target clamps to 11
        pulse(2, 1'b0, 15, 1'b1, 1'b0, 1'b0);
        chk("clamp.sat_hi", 64'(b2.sat_hi), 64'd1);
        wait_idle(2, 50);
        chk("clamp.code", 64'(b2.code_cur), 64'd11);
        chk("clamp.en", 64'(b2.en_ff), 64'h7FF);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
